// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART receive frame sequencer: phase encoding and data-bits limits.
// Imported by uart_frame_counter and by anything that decodes its phase output.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } phase_t;

  localparam logic [3:0] MIN_DATA_BITS = 4'd5;

  // Short fields are stretched to the minimum; long ones are cut to what the datapath holds.
  function automatic logic [3:0] clamp_data_bits(input logic [3:0] v, input logic [3:0] max_bits);
    if (v < MIN_DATA_BITS) return MIN_DATA_BITS;
    if (v > max_bits) return max_bits;
    return v;
  endfunction

endpackage

// File: rtl/uart_frame_counter.sv
// UART RX frame sequencer: walks start/data/[parity]/stop on bit_enb; parity field built only with UART_FRAME_CNT_PARITY_EN.
// Latency: all outputs registered, pulses on the edge sampling the cause. No backpressure: every strobe is consumed.
module uart_frame_counter
  import uart_frame_pkg::*;
#(
  parameter int MAX_DATA_BITS = 9,
  parameter int IDX_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             bit_enb,
  input  logic [3:0]       cfg_data_bits,
  input  logic             cfg_parity_en,
  input  logic             cfg_two_stop,
  output logic             busy,
  output logic [2:0]       phase,
  output logic [IDX_W-1:0] data_idx,
  output logic             data_valid,
  output logic             parity_valid,
  output logic             frame_done,
  output logic             frame_abort
);

  localparam logic [3:0] MAX_BITS = 4'(MAX_DATA_BITS);

  phase_t           state;
  logic [3:0]       lat_bits;
  logic             lat_two_stop;
  logic [IDX_W-1:0] cnt;
  logic             stop_cnt;
  logic [IDX_W-1:0] last_idx;

  assign phase    = state;
  assign last_idx = IDX_W'(lat_bits - 4'd1);

`ifdef UART_FRAME_CNT_PARITY_EN
  logic lat_parity;
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = cfg_parity_en;
  assign parity_valid      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      data_idx     <= '0;
      data_valid   <= 1'b0;
      frame_done   <= 1'b0;
      frame_abort  <= 1'b0;
      lat_bits     <= 4'd0;
      lat_two_stop <= 1'b0;
      cnt          <= '0;
      stop_cnt     <= 1'b0;
`ifdef UART_FRAME_CNT_PARITY_EN
      lat_parity   <= 1'b0;
      parity_valid <= 1'b0;
`endif
    end else begin
      data_valid  <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
`ifdef UART_FRAME_CNT_PARITY_EN
      parity_valid <= 1'b0;
`endif
      // frame_start always wins: a coincident strobe is dropped, even on the final stop bit.
      if (frame_start) begin
        frame_abort  <= busy;
        lat_bits     <= clamp_data_bits(cfg_data_bits, MAX_BITS);
        lat_two_stop <= cfg_two_stop;
`ifdef UART_FRAME_CNT_PARITY_EN
        lat_parity   <= cfg_parity_en;
`endif
        cnt          <= '0;
        stop_cnt     <= 1'b0;
        state        <= START;
        busy         <= 1'b1;
      end else if (bit_enb) begin
        case (state)
          START: begin
            cnt   <= '0;
            state <= DATA;
          end
          DATA: begin
            data_valid <= 1'b1;
            data_idx   <= cnt;
            cnt        <= cnt + 1'b1;
            if (cnt == last_idx) begin
              stop_cnt <= 1'b0;
`ifdef UART_FRAME_CNT_PARITY_EN
              state    <= lat_parity ? PARITY : STOP;
`else
              state    <= STOP;
`endif
            end
          end
`ifdef UART_FRAME_CNT_PARITY_EN
          PARITY: begin
            parity_valid <= 1'b1;
            state        <= STOP;
          end
`endif
          STOP: begin
            if (!lat_two_stop || stop_cnt) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              stop_cnt   <= 1'b0;
              state      <= IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
